alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Command front-end placed directly upstream of the 4-bit combinational ALU.
- Buffers operation requests in a small FIFO and issues one at a time to the ALU's A, B and alu_select inputs.
- Captures alu_out/carry_out and returns a flagged result through a valid/ready handshake.
- Keeps a result accumulator so chained operations can reuse the previous result as operand A.

Parameters:
WIDTH, 4, operand/result width; must match the ALU.
DEPTH, 4, command FIFO entries; power of two, >= 2.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset_L  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  FIFO can accept a command.
cmd_op  in  3  0 AND, 1 OR, 2 XOR, 3 ADD, 4 NOT(A), 5 SUB(A-B); 6 and 7 are illegal.
cmd_a  in  WIDTH  operand A.
cmd_b  in  WIDTH  operand B.
cmd_acc  in  1  1: use the accumulator as A and ignore cmd_a.
alu_a  out  WIDTH  to ALU A.
alu_b  out  WIDTH  to ALU B.
alu_select  out  3  to ALU alu_select.
alu_result  in  WIDTH  from ALU alu_out.
alu_carry  in  1  from ALU carry_out.
res_valid  out  1  result available.
res_ready  in  1  consumer accepts the result.
res_data  out  WIDTH  result value.
res_carry  out  1  carry; ADD only, otherwise 0.
res_zero  out  1  res_data == 0 for a legal op.
res_err  out  1  illegal opcode.
acc  out  WIDTH  current accumulator.
fifo_count  out  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, reset_L=0): FIFO empty, fifo_count=0, cmd_ready=1. All other outputs 0: alu_a, alu_b, alu_select, res_*, acc. FSM=IDLE.
- Reset mid-operation: any queued or in-flight command is dropped and no result is produced.
- FIFO push on cmd_valid && cmd_ready. cmd_ready = (fifo_count < DEPTH), combinational from count.
- Full FIFO: cmd_ready=0; a push is never accepted, even if a pop happens in the same cycle.
- Pointers wrap modulo DEPTH.
- Simultaneous push and pop when not full: count is unchanged and both entries are handled correctly.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if FIFO is non-empty, pop the head at the edge and go to EXEC.
    - Load alu_a (acc if entry.acc, else entry.a), alu_b and alu_select as registers.
    - For an illegal op, load alu_select=0 and latch an err bit.
  - EXEC: exactly one cycle so the ALU output settles. At the next edge, capture into the result registers, set res_valid=1 and go to RESP.
    - Legal op: res_data=alu_result; res_carry=alu_carry if op==3, else 0; res_zero=(alu_result==0); res_err=0; acc<=alu_result.
    - Illegal op: res_data=0, res_carry=0, res_zero=0, res_err=1; acc unchanged.
  - RESP: hold res_* stable while res_ready=0. On res_valid && res_ready, clear res_valid and go to IDLE.
    - res_data, res_carry, res_zero and res_err keep their last values after the handshake; only res_valid drops.
- Latency: a command accepted at edge N into an empty, idle block is popped at N+1. res_valid is high after edge N+2.
- Back-to-back throughput: one result per 3 cycles when res_ready is held at 1.
- alu_a, alu_b and alu_select hold their value from EXEC through RESP and IDLE until the next pop.
- Arithmetic: no wrap handling in this block. SUB wraps modulo 2^WIDTH in the ALU; the block passes the ALU result through unchanged.
- cmd_acc reads acc at pop time. Only one op is in flight, so acc always reflects the previous legal result.
- Commands leave in FIFO order; no reordering.

Test Plan:
1. Reset, then push {op=3, A=9, B=8}, res_ready=1 -> res_valid after edge N+2 with res_data=1, res_carry=1, res_zero=0; acc=1.
2. Push {op=5, A=3, B=3} then {op=3, cmd_acc=1, B=4} -> first result 0 with res_zero=1, res_carry=0; second result 4 (alu_a=0).
3. Hold res_ready=0 and push 5 commands (DEPTH=4) -> cmd_ready drops when fifo_count=4. The held result stays stable. Release res_ready and all 5 results return in order.
4. Push op=6, A=5, B=2 -> res_err=1, res_data=0, res_zero=0; acc unchanged; the next legal op proceeds normally.
5. Push op=4, A=0xA -> res_data=0x5, res_carry=0. Push op=2, A=0xF, B=0xF -> res_data=0, res_zero=1.
6. Pull reset_L low during EXEC with 2 commands queued -> all outputs 0 at once, fifo_count=0. No result appears after release.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command FIFO and single-issue driver for a 4-bit ALU.
// Returns flagged results over valid/ready and keeps a result accumulator.
module alu_op_sequencer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [WIDTH-1:0]         cmd_a,
    input  logic [WIDTH-1:0]         cmd_b,
    input  logic                     cmd_acc,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [2:0]               alu_select,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic                     alu_carry,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic                     res_carry,
    output logic                     res_zero,
    output logic                     res_err,
    output logic [WIDTH-1:0]         acc,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd5;

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             use_acc;
    } cmd_t;

    cmd_t          mem [DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    state;
    logic          err_q;
    logic          push;
    logic          pop;
    logic          head_legal;

    // A full FIFO refuses pushes even when a pop happens in the same cycle
    assign cmd_ready  = (fifo_count < CNT_FULL);
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state == IDLE) && (fifo_count != '0);
    assign head       = mem[rd_ptr];
    assign head_legal = (head.op <= OP_SUB);

    // Command storage; no reset needed, occupancy is tracked by the counters
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b, use_acc: cmd_acc};
        end
    end

    // FIFO pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Issue FSM: pop into ALU operand registers, capture one cycle later, hold until taken
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_select <= '0;
            err_q      <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_carry  <= 1'b0;
            res_zero   <= 1'b0;
            res_err    <= 1'b0;
            acc        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        alu_a      <= head.use_acc ? acc : head.a;
                        alu_b      <= head.b;
                        alu_select <= head_legal ? head.op : 3'd0;
                        err_q      <= !head_legal;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    res_valid <= 1'b1;
                    state     <= RESP;
                    if (err_q) begin
                        res_data  <= '0;
                        res_carry <= 1'b0;
                        res_zero  <= 1'b0;
                        res_err   <= 1'b1;
                    end else begin
                        res_data  <= alu_result;
                        res_carry <= (alu_select == OP_ADD) && alu_carry;
                        res_zero  <= (alu_result == '0);
                        res_err   <= 1'b0;
                        acc       <= alu_result;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
